// File: rtl/mem_loader_pkg.sv
// Shared definitions for the serial program loader: header byte, default
// memory geometry and the loader / byte-receiver state encodings.
package mem_loader_pkg;

    localparam int         DEF_BW  = 16;
    localparam int         DEF_AW  = 9;
    localparam logic [7:0] LDR_HDR = 8'hA5;

    typedef enum logic [2:0] {
        IDLE, CNT_H, CNT_L, DAT_H, DAT_L, CKSUM, DONE, ERR
    } ldr_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

endpackage

// File: rtl/mem_loader_uart_rx_byte.sv
// 8N1 UART byte receiver on an already-synchronised line; emits one-cycle
// valid_o (good stop bit) or ferr_o (stop bit low) strobes.
module uart_rx_byte
    import mem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_s,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       ferr_o
);

    localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          rx_d_q, valid_d, ferr_d;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            // Start only on a falling edge, so a line held low after a bad stop bit is not re-read.
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_d_q && !rx_s) state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == LAST) begin
                cnt_d = '0;
                sh_d  = {rx_s, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == LAST) begin
                valid_d = rx_s;
                ferr_d  = !rx_s;
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rx_d_q  <= 1'b0;
            valid_o <= 1'b0;
            ferr_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rx_d_q  <= rx_s;
            valid_o <= valid_d;
            ferr_o  <= ferr_d;
        end
    end

    assign byte_o = sh_q;

endmodule

// File: rtl/mem_loader.sv
// Serial program loader: writes a framed UART word image into main memory from
// address 0 while holding the CPU in reset. LOADER_CKSUM_EN adds a trailing XOR checksum byte.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int BW      = DEF_BW,
    parameter int AW      = DEF_AW,
    parameter int CLK_HZ  = 1000000,
    parameter int BAUD    = 9600,
    parameter int TO_CLKS = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    output logic [AW-1:0] mem_addr,
    output logic [BW-1:0] mem_data,
    output logic          mem_we,
    output logic          own_mem,
    output logic          cpu_rstn,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int DEPTH        = 2 ** AW;
    localparam int TW           = $clog2(TO_CLKS + 1);

    ldr_state_t    state_q, state_d;
    logic          rx_meta, rx_s;
    logic [7:0]    rx_byte;
    logic          rx_valid, rx_ferr;
    logic [7:0]    n_hi_q, hi_q;
    logic [15:0]   rem_q, count;
    logic [TW-1:0] to_cnt_q;
    logic          busy_st, start, ld_nhi, ld_cnt, ld_hi, wr_word;
`ifdef LOADER_CKSUM_EN
    logic [7:0]    ck_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx_s    (rx_s),
        .byte_o  (rx_byte),
        .valid_o (rx_valid),
        .ferr_o  (rx_ferr)
    );

    assign busy_st = state_q inside {CNT_H, CNT_L, DAT_H, DAT_L, CKSUM};
    assign count   = {n_hi_q, rx_byte};

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        ld_nhi  = 1'b0;
        ld_cnt  = 1'b0;
        ld_hi   = 1'b0;
        wr_word = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: if (rx_valid && rx_byte == LDR_HDR) begin
                start   = 1'b1;
                state_d = CNT_H;
            end
            CNT_H: if (rx_valid) begin
                ld_nhi  = 1'b1;
                state_d = CNT_L;
            end
            CNT_L: if (rx_valid) begin
                if (count == '0 || int'(count) > DEPTH) begin
                    state_d = ERR;
                end else begin
                    ld_cnt  = 1'b1;
                    state_d = DAT_H;
                end
            end
            DAT_H: if (rx_valid) begin
                ld_hi   = 1'b1;
                state_d = DAT_L;
            end
            DAT_L: if (rx_valid) begin
                wr_word = 1'b1;
`ifdef LOADER_CKSUM_EN
                state_d = (rem_q == 16'd1) ? CKSUM : DAT_H;
`else
                state_d = (rem_q == 16'd1) ? DONE : DAT_H;
`endif
            end
`ifdef LOADER_CKSUM_EN
            CKSUM: if (rx_valid) state_d = (rx_byte == ck_q) ? DONE : ERR;
`endif
            default: state_d = IDLE;
        endcase
        if (busy_st && (rx_ferr || (!rx_valid && to_cnt_q == TW'(TO_CLKS - 1))))
            state_d = ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            n_hi_q   <= '0;
            hi_q     <= '0;
            rem_q    <= '0;
            to_cnt_q <= '0;
        end else begin
            mem_we <= wr_word;
            if (ld_nhi) n_hi_q <= rx_byte;
            if (ld_hi)  hi_q   <= rx_byte;
            if (wr_word) begin
                mem_data <= BW'({hi_q, rx_byte});
                rem_q    <= rem_q - 16'd1;
            end else if (ld_cnt) begin
                rem_q <= count;
            end
            // Address advances the cycle after each write, wrapping at the top of memory.
            if (ld_cnt)      mem_addr <= '0;
            else if (mem_we) mem_addr <= mem_addr + AW'(1);
            if (!busy_st || rx_valid || rx_ferr) to_cnt_q <= '0;
            else                                 to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

`ifdef LOADER_CKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  ck_q <= '0;
        else if (start)           ck_q <= '0;
        else if (ld_hi || wr_word) ck_q <= ck_q ^ rx_byte;
    end
`endif

    // The final write keeps the port owned and the CPU held until it has landed.
    assign busy     = busy_st || mem_we;
    assign own_mem  = busy;
    assign done     = (state_q == DONE) && !mem_we;
    assign err      = (state_q == ERR);
    assign cpu_rstn = (state_q == IDLE || state_q == DONE) && !mem_we;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table of framed loads plus hand-written
// sequences for the full-depth wrap, timeout, reset mid-load and stray bytes.
module tb_mem_loader;

    localparam int CPB     = 4;
    localparam int TO_CLKS = 200;
`ifdef LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [8:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_we, own_mem, cpu_rstn, busy, done, err;

    mem_loader #(
        .BW(16), .AW(9), .CLK_HZ(40), .BAUD(10), .TO_CLKS(TO_CLKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .own_mem  (own_mem),
        .cpu_rstn (cpu_rstn),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Write monitor: logs every mem_we cycle and flags stretched pulses or unowned writes.
    int          wr_n      = 0;
    int          we_double = 0;
    int          own_bad   = 0;
    logic        prev_we   = 1'b0;
    logic [8:0]  wr_addr_log [1024];
    logic [15:0] wr_data_log [1024];

    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_n < 1024) begin
                wr_addr_log[wr_n] = mem_addr;
                wr_data_log[wr_n] = mem_data;
            end
            wr_n++;
            if (!own_mem) own_bad++;
            if (prev_we)  we_double++;
        end
        prev_we = mem_we;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = good_stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    typedef struct packed {
        logic [0:9][7:0] fr;
        int              n;
        int              bad;      // index of byte sent with a low stop bit; 99 = none
        bit              add_ck;   // append the XOR checksum when the checksum build is used
        int              exp_wr;
        bit              exp_done;
        bit              exp_err;
        bit              exp_rstn;
        int              exp_addr; // 999 = not checked
        logic [15:0]     w0;
        logic [15:0]     w1;
    } vec_t;

    vec_t  vecs   [7];
    string vnames [7];

    initial begin
        vec_t       v;
        int         base;
        int         bad_cnt;
        logic [7:0] ck;

        vnames[0] = "frame1";
        vecs[0] = '{fr: {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00},
                    n: 7, bad: 99, add_ck: 1'b1, exp_wr: 2, exp_done: 1'b1, exp_err: 1'b0,
                    exp_rstn: 1'b1, exp_addr: 2, w0: 16'h1234, w1: 16'hABCD};
        vnames[1] = "n_zero";
        vecs[1] = '{fr: {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 3, bad: 99, add_ck: 1'b0, exp_wr: 0, exp_done: 1'b0, exp_err: 1'b1,
                    exp_rstn: 1'b0, exp_addr: 999, w0: 16'h0, w1: 16'h0};
        vnames[2] = "frame1_again";
        vecs[2] = vecs[0];
        vnames[3] = "n_513";
        vecs[3] = '{fr: {8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 3, bad: 99, add_ck: 1'b0, exp_wr: 0, exp_done: 1'b0, exp_err: 1'b1,
                    exp_rstn: 1'b0, exp_addr: 999, w0: 16'h0, w1: 16'h0};
        vnames[4] = "bad_stop";
        vecs[4] = '{fr: {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00},
                    n: 7, bad: 5, add_ck: 1'b0, exp_wr: 1, exp_done: 1'b0, exp_err: 1'b1,
                    exp_rstn: 1'b0, exp_addr: 1, w0: 16'h1234, w1: 16'h0};
        vnames[5] = "cksum_41";
        vecs[5] = '{fr: {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00, 8'h00},
                    n: 8, bad: 99, add_ck: 1'b0, exp_wr: 2, exp_done: !CK, exp_err: CK,
                    exp_rstn: !CK, exp_addr: 2, w0: 16'h1234, w1: 16'hABCD};
        vnames[6] = "one_word";
        vecs[6] = '{fr: {8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 5, bad: 99, add_ck: 1'b1, exp_wr: 1, exp_done: 1'b1, exp_err: 1'b0,
                    exp_rstn: 1'b1, exp_addr: 1, w0: 16'hBEEF, w1: 16'h0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst.mem_addr", 32'(mem_addr), 0);
        check("rst.mem_data", 32'(mem_data), 0);
        check("rst.mem_we",   32'(mem_we),   0);
        check("rst.own_mem",  32'(own_mem),  0);
        check("rst.cpu_rstn", 32'(cpu_rstn), 1);
        check("rst.busy",     32'(busy),     0);
        check("rst.done",     32'(done),     0);
        check("rst.err",      32'(err),      0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            v    = vecs[k];
            base = wr_n;
            ck   = 8'h00;
            for (int i = 0; i < v.n; i++) begin
                send_byte(v.fr[i], i != v.bad);
                if (i >= 3) ck = ck ^ v.fr[i];
                if (i == 0) begin
                    repeat (3) @(negedge clk);
                    check({vnames[k], ".hdr_busy"},  32'(busy),     1);
                    check({vnames[k], ".hdr_rstn"},  32'(cpu_rstn), 0);
                end
                if (i == v.bad) break;
            end
            if (CK && v.add_ck) send_byte(ck, 1'b1);
            repeat (16) @(negedge clk);
            check({vnames[k], ".writes"},   32'(wr_n - base), 32'(v.exp_wr));
            check({vnames[k], ".done"},     32'(done),        32'(v.exp_done));
            check({vnames[k], ".err"},      32'(err),         32'(v.exp_err));
            check({vnames[k], ".cpu_rstn"}, 32'(cpu_rstn),    32'(v.exp_rstn));
            check({vnames[k], ".busy"},     32'(busy),        0);
            check({vnames[k], ".own_mem"},  32'(own_mem),     0);
            if (v.exp_addr != 999)
                check({vnames[k], ".mem_addr"}, 32'(mem_addr), 32'(v.exp_addr));
            if (v.exp_wr >= 1 && wr_n - base >= 1) begin
                check({vnames[k], ".w0_addr"}, 32'(wr_addr_log[base]), 0);
                check({vnames[k], ".w0_data"}, 32'(wr_data_log[base]), 32'(v.w0));
            end
            if (v.exp_wr >= 2 && wr_n - base >= 2) begin
                check({vnames[k], ".w1_addr"}, 32'(wr_addr_log[base + 1]), 1);
                check({vnames[k], ".w1_data"}, 32'(wr_data_log[base + 1]), 32'(v.w1));
            end
        end

        // Full depth: N=512 words of 0xFFFF, address wraps back to 0
        base = wr_n;
        ck   = 8'h00;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 1024; i++) begin
            send_byte(8'hFF, 1'b1);
            ck = ck ^ 8'hFF;
        end
        if (CK) send_byte(ck, 1'b1);
        repeat (16) @(negedge clk);
        check("n512.writes",   32'(wr_n - base), 512);
        bad_cnt = 0;
        for (int i = 0; i < 512; i++)
            if (base + i < 1024 &&
                (wr_addr_log[base + i] !== 9'(i) || wr_data_log[base + i] !== 16'hFFFF))
                bad_cnt++;
        check("n512.bad_words", 32'(bad_cnt),  0);
        check("n512.mem_addr",  32'(mem_addr), 0);
        check("n512.done",      32'(done),     1);
        check("n512.cpu_rstn",  32'(cpu_rstn), 1);

        // Inter-byte timeout during a load
        base = wr_n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (4) @(negedge clk);
        check("tmo.busy_before", 32'(busy), 1);
        repeat (TO_CLKS + 20) @(negedge clk);
        check("tmo.err",      32'(err),         1);
        check("tmo.busy",     32'(busy),        0);
        check("tmo.cpu_rstn", 32'(cpu_rstn),    0);
        check("tmo.writes",   32'(wr_n - base), 0);

        // Reset in the middle of the low data byte
        base = wr_n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("mid.busy",     32'(busy),     1);
        check("mid.cpu_rstn", 32'(cpu_rstn), 0);
        rst = 1'b1;
        #1;
        check("arst.busy",     32'(busy),          0);
        check("arst.own_mem",  32'(own_mem),       0);
        check("arst.cpu_rstn", 32'(cpu_rstn),      1);
        check("arst.done",     32'(done),          0);
        check("arst.err",      32'(err),           0);
        check("arst.mem_we",   32'(mem_we),        0);
        check("arst.mem_addr", 32'(mem_addr),      0);
        check("arst.state",    32'(dut.state_q),   0);
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (4 * CPB) @(negedge clk);

        // A stray non-header byte in IDLE is ignored
        send_byte(8'h55, 1'b1);
        repeat (16) @(negedge clk);
        check("stray.busy",     32'(busy),        0);
        check("stray.done",     32'(done),        0);
        check("stray.err",      32'(err),         0);
        check("stray.cpu_rstn", 32'(cpu_rstn),    1);
        check("stray.writes",   32'(wr_n - base), 0);

        check("mon.we_width",  32'(we_double), 0);
        check("mon.own_write", 32'(own_bad),   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
